// File: rtl/fixed_stream_pkg.sv
// Shared types and constants for the fixed-point sweep stream source.
package fixed_stream_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sweep_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/fixed_stream_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pace inter-beat gaps.
module fixed_stream_lfsr
    import fixed_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= LFSR_SEED;
        else     q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end

endmodule

// File: rtl/fixed_stream_sweep_source.sv
// Valid/ready source sweeping a signed range start..end by step, P lanes per beat.
// Define FIXED_STREAM_SOURCE_GAP_EN to insert LFSR-paced bubbles between beats.
module fixed_stream_sweep_source
    import fixed_stream_pkg::*;
#(
    parameter int DATA_OUT_0_PRECISION_0       = 16,
    parameter int DATA_OUT_0_PRECISION_1       = 0,
    parameter int DATA_OUT_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_OUT_0_PARALLELISM_DIM_1 = 1,
    parameter int COUNT_WIDTH                  = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic [DATA_OUT_0_PRECISION_0-1:0] sweep_start,
    input  logic [DATA_OUT_0_PRECISION_0-1:0] sweep_end,
    input  logic [DATA_OUT_0_PRECISION_0-1:0] sweep_step,
    output logic [DATA_OUT_0_PARALLELISM_DIM_0*DATA_OUT_0_PARALLELISM_DIM_1-1:0]
                 [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic [DATA_OUT_0_PARALLELISM_DIM_0*DATA_OUT_0_PARALLELISM_DIM_1-1:0] data_out_0_keep,
    output logic data_out_0_valid,
    input  logic data_out_0_ready,
    output logic busy,
    output logic done,
    output logic [COUNT_WIDTH-1:0] beat_count
);

    localparam int W  = DATA_OUT_0_PRECISION_0;
    localparam int P  = DATA_OUT_0_PARALLELISM_DIM_0 * DATA_OUT_0_PARALLELISM_DIM_1;
    // Wide enough for base + (P-1)*step and the next-beat base without wrapping.
    localparam int SW = W + 1 + $clog2(P);

    typedef logic signed [SW-1:0] wide_t;

    localparam wide_t P_W = wide_t'(P);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic wide_t sext(input logic [W-1:0] x);
        return {{(SW-W){x[W-1]}}, x};
    endfunction

    function automatic logic incl(input wide_t v, input wide_t e, input wide_t s);
        return ((s > 0) && (v <= e)) || ((s < 0) && (v >= e));
    endfunction

    sweep_state_t state;
    wide_t        cfg_end, cfg_step, base;
    logic         last;

    wide_t src_base, src_end, src_step, nxt_base;
    logic  src_last, idle, hs;

    wide_t                 lane_v [P];
    logic [P-1:0][W-1:0]   lane_data;
    logic [P-1:0]          lane_keep;

    assign idle = (state == IDLE);
    assign hs   = data_out_0_valid & data_out_0_ready;

    // In IDLE the lane datapath previews the first beat from the raw inputs;
    // in RUN it previews the beat following the one on the bus.
    assign src_end  = idle ? sext(sweep_end)   : cfg_end;
    assign src_step = idle ? sext(sweep_step)  : cfg_step;
    assign src_base = idle ? sext(sweep_start) : base + P_W * cfg_step;
    assign nxt_base = src_base + P_W * src_step;
    assign src_last = (src_step == '0) || !incl(nxt_base, src_end, src_step);

    for (genvar k = 0; k < P; k++) begin : g_lane
        localparam wide_t K_W = wide_t'(k);
        assign lane_v[k]    = src_base + K_W * src_step;
        assign lane_keep[k] = (k == 0) || incl(lane_v[k], src_end, src_step);
        assign lane_data[k] = lane_keep[k] ? lane_v[k][W-1:0] : '0;
    end

`ifdef FIXED_STREAM_SOURCE_GAP_EN
    logic [15:0] lfsr;
    logic [2:0]  gap_cnt;

    fixed_stream_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cfg_end          <= '0;
            cfg_step         <= '0;
            base             <= '0;
            last             <= 1'b0;
            data_out_0       <= '0;
            data_out_0_keep  <= '0;
            data_out_0_valid <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            beat_count       <= '0;
`ifdef FIXED_STREAM_SOURCE_GAP_EN
            gap_cnt          <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state            <= RUN;
                        busy             <= 1'b1;
                        cfg_end          <= src_end;
                        cfg_step         <= src_step;
                        base             <= src_base;
                        last             <= src_last;
                        data_out_0       <= lane_data;
                        data_out_0_keep  <= lane_keep;
                        data_out_0_valid <= 1'b1;
                        beat_count       <= '0;
`ifdef FIXED_STREAM_SOURCE_GAP_EN
                        gap_cnt          <= '0;
`endif
                    end
                end
                RUN: begin
                    if (hs) begin
                        beat_count <= beat_count + CNT_ONE;
                        if (last) begin
                            state            <= DONE;
                            data_out_0       <= '0;
                            data_out_0_keep  <= '0;
                            data_out_0_valid <= 1'b0;
                            done             <= 1'b1;
                        end else begin
                            base            <= src_base;
                            last            <= src_last;
                            data_out_0      <= lane_data;
                            data_out_0_keep <= lane_keep;
`ifdef FIXED_STREAM_SOURCE_GAP_EN
                            if (lfsr[1:0] == 2'b00) begin
                                data_out_0_valid <= 1'b0;
                                gap_cnt          <= {1'b0, lfsr[3:2]} + 3'd1;
                            end else begin
                                data_out_0_valid <= 1'b1;
                            end
`else
                            data_out_0_valid <= 1'b1;
`endif
                        end
                    end
`ifdef FIXED_STREAM_SOURCE_GAP_EN
                    else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 3'd1;
                        if (gap_cnt == 3'd1) data_out_0_valid <= 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_stream_sweep_source.sv
// Scoreboard bench for fixed_stream_sweep_source with 4 lanes (2x2), W=16.
module tb_fixed_stream_sweep_source;

    localparam int W  = 16;
    localparam int P  = 4;
    localparam int CW = 32;

    typedef struct packed {
        logic [P-1:0][W-1:0] data;
        logic [P-1:0]        keep;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [W-1:0] s_start = '0, s_end = '0, s_step = '0;
    logic [P-1:0][W-1:0] data;
    logic [P-1:0] keep;
    logic valid, busy, done;
    logic ready = 1'b1;
    logic [CW-1:0] beat_count;

    always #5 clk = ~clk;

    fixed_stream_sweep_source #(
        .DATA_OUT_0_PRECISION_0       (W),
        .DATA_OUT_0_PRECISION_1       (0),
        .DATA_OUT_0_PARALLELISM_DIM_0 (2),
        .DATA_OUT_0_PARALLELISM_DIM_1 (2),
        .COUNT_WIDTH                  (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .sweep_start      (s_start),
        .sweep_end        (s_end),
        .sweep_step       (s_step),
        .data_out_0       (data),
        .data_out_0_keep  (keep),
        .data_out_0_valid (valid),
        .data_out_0_ready (ready),
        .busy             (busy),
        .done             (done),
        .beat_count       (beat_count)
    );

    beat_t exp_q[$];
    int    exp_cnt_q[$];
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push4(input int a, input int b, input int c, input int d, input logic [3:0] k);
        beat_t x;
        x.data[0] = W'(a);
        x.data[1] = W'(b);
        x.data[2] = W'(c);
        x.data[3] = W'(d);
        x.keep    = k;
        exp_q.push_back(x);
    endtask

    // Monitor: pops the scoreboard on every handshake and done pulse.
    beat_t mon_e, prev;
    int    mon_c;
    logic  prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!valid || data !== prev.data || keep !== prev.keep) begin
                    failures++;
                    $display("FAIL hold_stable actual=%0b/%0h/%0h required=1/%0h/%0h",
                             valid, data, keep, prev.data, prev.keep);
                end
            end
            if (valid && ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h/%0h required=none", data, keep);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (data !== mon_e.data || keep !== mon_e.keep) begin
                        failures++;
                        $display("FAIL beat actual=%0h/%0h required=%0h/%0h",
                                 data, keep, mon_e.data, mon_e.keep);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_cnt_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    mon_c = exp_cnt_q.pop_front();
                    if (beat_count !== CW'(mon_c)) begin
                        failures++;
                        $display("FAIL beat_count actual=%0d required=%0d", beat_count, mon_c);
                    end
                end
            end
            prev_stall = valid && !ready;
            prev.data  = data;
            prev.keep  = keep;
        end
    end

    // Ready driver: mode 1 gives the repeating 1-0-0-1 pattern.
    int mode = 0;
    int cyc  = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        ready = (mode == 1) ? !((cyc % 4 == 1) || (cyc % 4 == 2)) : 1'b1;
    end

    task automatic issue(input int s, input int e, input int st);
        @(posedge clk); #1;
        s_start = W'(s); s_end = W'(e); s_step = W'(st);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the range inputs: the sweep must use the latched copies.
        s_start = 16'h1234; s_end = 16'h0000; s_step = 16'h0007;
        chk("valid_latency", valid, 1);
        chk("busy_run", busy, 1);
    endtask

    task automatic do_sweep(input int s, input int e, input int st, input int n_exp, input int exp_cyc);
        int  n;
        bit  seen;
        exp_cnt_q.push_back(n_exp);
        issue(s, e, st);
        n = 0;
        seen = 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done");
        end else if (exp_cyc > 0) begin
            chk("done_cycle", n, exp_cyc);
        end
        @(posedge clk); #1;
        chk("idle_after_done", {busy, done}, 2'b00);
    endtask

    task automatic push_m8_8();
        push4(-8, -7, -6, -5, 4'b1111);
        push4(-4, -3, -2, -1, 4'b1111);
        push4( 0,  1,  2,  3, 4'b1111);
        push4( 4,  5,  6,  7, 4'b1111);
        push4( 8,  0,  0,  0, 4'b0001);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_keep", keep, 0);
        chk("reset_data", data, 0);
        chk("reset_count", beat_count, 0);

        push_m8_8();
        do_sweep(-8, 8, 1, 5, 6);

        push4(0, 3, 6, 9, 4'b1111);
        do_sweep(0, 9, 3, 1, 2);
        push4(0, 3, 6, 9, 4'b1111);
        do_sweep(0, 10, 3, 1, 2);
        push4(0, 3, 6, 9, 4'b1111);
        push4(12, 0, 0, 0, 4'b0001);
        do_sweep(0, 13, 3, 2, 3);

        push4(5, 0, 0, 0, 4'b0001);
        do_sweep(5, 9, 0, 1, 2);
        push4(5, 0, 0, 0, 4'b0001);
        do_sweep(5, 0, 1, 1, 2);
        push4(32760, 32764, 0, 0, 4'b0011);
        do_sweep(32760, 32767, 4, 1, 2);
        push4(-32760, -32764, -32768, 0, 4'b0111);
        do_sweep(-32760, -32768, -4, 1, 2);

        mode = 1;
        push4(7, 5, 3, 1, 4'b1111);
        push4(-1, -3, 0, 0, 4'b0011);
        do_sweep(7, -3, -2, 2, -1);
        push_m8_8();
        do_sweep(-8, 8, 1, 5, -1);
        mode = 0;
        @(posedge clk);

        // Reset while beat 3 is on the bus.
        push_m8_8();
        issue(-8, 8, 1);
        n = 0;
        while (beat_count != 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_beat3", beat_count, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", beat_count, 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        push_m8_8();
        do_sweep(-8, 8, 1, 5, 6);

        repeat (3) @(posedge clk);
        chk("scoreboard_beats_left", exp_q.size(), 0);
        chk("scoreboard_done_left", exp_cnt_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
